time_entry_sequencer: RTL
=========================

Name: time_entry_sequencer

Overview:
- Keypad-entry front end for the clock-setting path. Sits directly upstream of the digit register stage that holds LH/RH/LM/RM.
- Steps through the four time digits in order and range-checks each key against 24h or 12h limits.
- Emits one-cycle digit-select strobes plus the digit value, and qualifies them with setSignal/alarmSignal.
- Supports backspace, cancel and end-of-entry handshake.

Parameters:
- FORMAT_24H, 1, 1 = 24-hour limits; 0 = 12-hour limits.
- TIMEOUT_CYCLES, 500000000, idle-key cycles before auto-abort (used only with ENTRY_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- setReq  in  1  level; user requests time setting.
- alarmReq  in  1  level; user requests alarm setting.
- keyValid  in  1  one-cycle strobe; keyCode valid.
- keyCode  in  4  0-9 digit, 4'hA backspace, 4'hB cancel, 4'hC-4'hF reserved.
- setLH/setRH/setLM/setRM  out  1 each  one-cycle digit-select strobes (registered).
- numPad  out  4  digit value, valid with any set strobe.
- setSignal  out  1  time-set session active.
- alarmSignal  out  1  alarm-set session active.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse after RM accepted.
- keyError  out  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset (rst_n low at posedge): state IDLE. All outputs 0. Stored LH = 0.
- States: IDLE, E_LH, E_RH, E_LM, E_RM, COMMIT, WAIT_REL.
- IDLE -> E_LH when setReq or alarmReq is high.
  - setReq has priority if both are high.
  - The chosen mode is latched into setSignal or alarmSignal (exactly one), held high through WAIT_REL.
- In E_x, a keyValid with a digit:
  - Legal digit: next cycle the matching setX = 1 and numPad = digit (1-cycle latency). State advances. E_RM goes to COMMIT.
  - Illegal digit: keyError pulses next cycle. State unchanged. No strobe.
- Limits with FORMAT_24H=1: LH 0-2; RH 0-9, but 0-3 if LH==2; LM 0-5; RM 0-9.
- Limits with FORMAT_24H=0: LH 0-1; RH 1-9 if LH==0, 0-2 if LH==1; LM 0-5; RM 0-9.
- The accepted LH is stored internally for the RH check.
- Backspace (4'hA):
  - Moves to the previous E_ state; no strobe is emitted.
  - In E_LH it is a no-op.
  - The previous digit must be re-entered.
- Cancel (4'hB), or the latched request input dropping low in any E_ state:
  - Next cycle goes to IDLE, with setSignal/alarmSignal deasserted.
  - No done pulse.
- Reserved codes 4'hC-4'hF produce a keyError pulse; state unchanged.
- COMMIT: done = 1 for one cycle. keyValid is ignored. Next state is WAIT_REL.
- WAIT_REL: keys are ignored. When both setReq and alarmReq are low, go to IDLE and drop the mode signals in the same cycle. This prevents re-triggering.
- Set strobes are mutually exclusive; at most one is high per cycle.
- keyValid in IDLE is ignored, with no error.
- busy = (state != IDLE).

Optional Feature:
- ENTRY_TIMEOUT_EN defined:
  - A 32-bit counter clears on each keyValid and on entry to E_LH.
  - It increments in E_ states.
  - When it reaches TIMEOUT_CYCLES-1, the FSM aborts to IDLE exactly as on cancel.
- ENTRY_TIMEOUT_EN undefined: no counter is built; entry waits indefinitely.

Decomposition:
- Package time_entry_pkg holds:
  - the state enum;
  - key codes KEY_BACK = 4'hA and KEY_CANCEL = 4'hB;
  - the digit-limit constants (LH/LM maxima for both formats).
- One sub-module: digit_limit_check, combinational. Inputs: state, stored LH, digit, FORMAT_24H. Output: legal.
- The timeout counter stays inline under the macro.

Test Plan:
- setReq=1, keys 1,9,4,5 -> setLH/numPad=1, setRH/9, setLM/4, setRM/5 each 1 cycle after its key; done pulses the cycle after setRM; setSignal high throughout until setReq=0.
- 24h, alarmReq=1, keys 2,4 -> keyError pulse on 4, no setRH; then 3 -> setRH numPad=3; alarmSignal=1 and setSignal=0 throughout.
- Keys 1,A,2 -> setLH/1 then no strobe on backspace, state E_LH, then setLH/2; a key of 6 in E_LM -> keyError.
- Mid-entry key B, or setReq dropped after LH -> IDLE next cycle, setSignal=0, done never pulses; rst_n=0 mid-entry -> all outputs 0 next edge.
- FORMAT_24H=0: LH=0,RH=0 -> keyError; LH=1,RH=3 -> keyError; LH=1,RH=2 accepted. setReq and alarmReq raised together -> setSignal=1 only.
- ENTRY_TIMEOUT_EN with TIMEOUT_CYCLES=8: no key for 8 cycles in E_RH -> IDLE, busy=0; a key at cycle 7 restarts the count.

Source files
------------

// File: rtl/time_entry_pkg.sv
// Shared state encoding, key codes and digit limits for the time-entry keypad path.
package time_entry_pkg;

  typedef logic [2:0] entryState_t;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_E_LH     = 3'd1;
  localparam logic [2:0] S_E_RH     = 3'd2;
  localparam logic [2:0] S_E_LM     = 3'd3;
  localparam logic [2:0] S_E_RM     = 3'd4;
  localparam logic [2:0] S_COMMIT   = 3'd5;
  localparam logic [2:0] S_WAIT_REL = 3'd6;

  localparam logic [3:0] KEY_BACK   = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;

  localparam logic [3:0] DIGIT_MAX       = 4'd9;
  localparam logic [3:0] LH_MAX_24H      = 4'd2;
  localparam logic [3:0] LH_MAX_12H      = 4'd1;
  localparam logic [3:0] LM_MAX          = 4'd5;
  localparam logic [3:0] RH_MAX_LH2_24H  = 4'd3;
  localparam logic [3:0] RH_MAX_LH1_12H  = 4'd2;
  localparam logic [3:0] RH_MIN_LH0_12H  = 4'd1;

  function automatic logic isEntryState(input entryState_t s);
    return (s == S_E_LH) || (s == S_E_RH) || (s == S_E_LM) || (s == S_E_RM);
  endfunction

endpackage

// File: rtl/digit_limit_check.sv
// Combinational range check of a keyed digit against the digit currently being entered.
module digit_limit_check
  import time_entry_pkg::*;
#(
  parameter bit FORMAT_24H = 1'b1
) (
  input  logic [2:0] state,
  input  logic [3:0] storedLh,
  input  logic [3:0] digit,
  output logic       legal
);

  logic [3:0] loLimit;
  logic [3:0] hiLimit;

  always_comb begin
    loLimit = 4'd0;
    hiLimit = DIGIT_MAX;
    case (state)
      S_E_LH: hiLimit = FORMAT_24H ? LH_MAX_24H : LH_MAX_12H;
      S_E_RH: begin
        // The hour tens digit narrows the range of the hour units digit.
        if (FORMAT_24H) begin
          if (storedLh == LH_MAX_24H) hiLimit = RH_MAX_LH2_24H;
        end else if (storedLh == 4'd0) begin
          loLimit = RH_MIN_LH0_12H;
        end else begin
          hiLimit = RH_MAX_LH1_12H;
        end
      end
      S_E_LM: hiLimit = LM_MAX;
      default: ;
    endcase
    legal = (digit >= loLimit) && (digit <= hiLimit);
  end

endmodule

// File: rtl/time_entry_sequencer.sv
// Keypad entry sequencer for LH/RH/LM/RM with backspace, cancel and release handshake.
// Optional idle-key auto-abort is built when ENTRY_TIMEOUT_EN is defined.
module time_entry_sequencer
  import time_entry_pkg::*;
#(
  parameter bit          FORMAT_24H     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 32'd500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       setReq,
  input  logic       alarmReq,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  output logic       setLH,
  output logic       setRH,
  output logic       setLM,
  output logic       setRM,
  output logic [3:0] numPad,
  output logic       setSignal,
  output logic       alarmSignal,
  output logic       busy,
  output logic       done,
  output logic       keyError
);

  entryState_t stateReg, stateNext;
  logic [3:0]  lhReg, lhNext;
  logic        setSignalNext, alarmSignalNext;
  logic [3:0]  strobeNext;
  logic [3:0]  numPadNext;
  logic        doneNext, keyErrorNext;
  logic        legal, reqHeld, timeoutHit;

  digit_limit_check #(.FORMAT_24H(FORMAT_24H)) uLimit (
    .state   (stateReg),
    .storedLh(lhReg),
    .digit   (keyCode),
    .legal   (legal)
  );

`ifdef ENTRY_TIMEOUT_EN
  logic [31:0] timeoutCntReg;

  always_ff @(posedge clk) begin
    if (!rst_n || keyValid || !isEntryState(stateReg)) timeoutCntReg <= 32'd0;
    else                                               timeoutCntReg <= timeoutCntReg + 32'd1;
  end

  // A key arriving on the terminal count wins over the abort.
  assign timeoutHit = isEntryState(stateReg) && !keyValid &&
                      (timeoutCntReg == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeoutHit = 1'b0 && (TIMEOUT_CYCLES == 32'd0);
`endif

  assign reqHeld = (setSignal & setReq) | (alarmSignal & alarmReq);
  assign busy    = (stateReg != S_IDLE);

  always_comb begin
    stateNext       = stateReg;
    lhNext          = lhReg;
    setSignalNext   = setSignal;
    alarmSignalNext = alarmSignal;
    strobeNext      = 4'b0000;
    numPadNext      = 4'd0;
    doneNext        = 1'b0;
    keyErrorNext    = 1'b0;
    case (stateReg)
      S_IDLE: begin
        if (setReq || alarmReq) begin
          stateNext       = S_E_LH;
          setSignalNext   = setReq;
          alarmSignalNext = ~setReq;
        end
      end
      S_E_LH, S_E_RH, S_E_LM, S_E_RM: begin
        if (!reqHeld || timeoutHit || (keyValid && keyCode == KEY_CANCEL)) begin
          stateNext       = S_IDLE;
          setSignalNext   = 1'b0;
          alarmSignalNext = 1'b0;
        end else if (keyValid) begin
          if (keyCode == KEY_BACK) begin
            if (stateReg != S_E_LH) stateNext = stateReg - 3'd1;
          end else if ((keyCode <= DIGIT_MAX) && legal) begin
            // Strobe order is {LH,RH,LM,RM}; state codes are consecutive.
            strobeNext = 4'b1000 >> (stateReg - S_E_LH);
            numPadNext = keyCode;
            stateNext  = stateReg + 3'd1;
            if (stateReg == S_E_LH) lhNext = keyCode;
          end else begin
            keyErrorNext = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        doneNext  = 1'b1;
        stateNext = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!setReq && !alarmReq) begin
          stateNext       = S_IDLE;
          setSignalNext   = 1'b0;
          alarmSignalNext = 1'b0;
        end
      end
      default: begin
        stateNext       = S_IDLE;
        setSignalNext   = 1'b0;
        alarmSignalNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg                     <= S_IDLE;
      lhReg                        <= 4'd0;
      setSignal                    <= 1'b0;
      alarmSignal                  <= 1'b0;
      {setLH, setRH, setLM, setRM} <= 4'b0000;
      numPad                       <= 4'd0;
      done                         <= 1'b0;
      keyError                     <= 1'b0;
    end else begin
      stateReg                     <= stateNext;
      lhReg                        <= lhNext;
      setSignal                    <= setSignalNext;
      alarmSignal                  <= alarmSignalNext;
      {setLH, setRH, setLM, setRM} <= strobeNext;
      numPad                       <= numPadNext;
      done                         <= doneNext;
      keyError                     <= keyErrorNext;
    end
  end

endmodule
